fp16_mac_sequencer: RTL

Command-driven controller that sequences one FP16 MAC unit through a dot product of programmable length. It accepts a length command and streams operand pairs into the MAC with valid/ready flow control. It asserts accumulator clear on the first element, drains the MAC's output register, then returns the FP16 sum on a result handshake. It sits between the operand buffers / host command path and a single MAC cell (enable, acc_clear, a_in, w_in, acc_out).

---
 rtl/fp16_mac_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/fp16_mac_sequencer.sv
// Sequences one FP16 MAC through a length-programmable dot product; result appears DRAIN_CYCLES+2 cycles after the last element.
// Operands stall under in_valid low, the result is held under out_ready low, and commands wait in IDLE.
module fp16_mac_sequencer #(
  parameter int LEN_W        = 8,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_w,
  output logic             mac_enable,
  output logic             mac_acc_clear,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_w,
  input  logic [15:0]      mac_acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             busy,
  output logic [LEN_W-1:0] elem_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STREAM  = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESULT  = 3'd4
  } state_t;

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [DW-1:0]    drain_q;
  logic [15:0]      out_data_q;
  logic             stream_hs;

  assign stream_hs = (state_q == ST_STREAM) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      drain_q    <= '0;
      out_data_q <= 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            len_q <= cmd_len;
            cnt_q <= '0;
            if (cmd_len == '0) begin
              out_data_q <= 16'h0000;
              state_q    <= ST_RESULT;
            end else begin
              state_q <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (in_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) begin
              drain_q <= '0;
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Zero-product enables push the final sum through the MAC output register.
          if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
            state_q <= ST_CAPTURE;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        ST_CAPTURE: begin
          out_data_q <= mac_acc_out;
          state_q    <= ST_RESULT;
        end
        ST_RESULT: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign in_ready      = (state_q == ST_STREAM);
  assign out_valid     = (state_q == ST_RESULT);
  assign busy          = (state_q != ST_IDLE);
  assign out_data      = out_data_q;
  assign elem_cnt      = cnt_q;
  assign mac_enable    = stream_hs || (state_q == ST_DRAIN);
  // The first element loads rather than adds, so aborted commands cannot leak into a result.
  assign mac_acc_clear = stream_hs && (cnt_q == '0);
  assign mac_a         = stream_hs ? in_a : 16'h0000;
  assign mac_w         = stream_hs ? in_w : 16'h0000;

endmodule
